pc_control_unit: RTL and testbench

Parametrised program-counter unit for the multicycle CPU datapath. It extends the plain PC register with:
- conditional-branch evaluation (BEQ/BNE polarity),
- exception redirect with EPC capture and return,
- a small circular return-address stack (RAS) for call/return.

It sits between the PCSource mux and the instruction-memory address input, and is driven by the control FSM.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_ras.sv | 88 ++++++++
 rtl/pc_control_unit.sv | 154 +++++++++++++++
 tb/tb_pc_control_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   DEFAULT_RESET_VECTOR / DEFAULT_EXC_VECTOR : default load values
//   ras_ptr_width()                           : pointer width for a RAS of given depth
//   pc_src_e                                  : next-PC source selected by the priority logic
package pc_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

  typedef enum logic [2:0] {
    PcSrcHold,
    PcSrcExc,
    PcSrcEret,
    PcSrcRas,
    PcSrcTake
  } pc_src_e;

  function automatic int unsigned ras_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   clk, reset  : clock, asynchronous active-high reset
//   push, pop   : stack operations (caller gates them when suppressed)
//   push_data   : value written on push
//   top         : most recently pushed entry
//   empty, full : occupancy flags
//   underflow   : registered one-cycle pulse when pop is requested on an empty stack
// A push when full overwrites the oldest entry; push+pop on a non-empty stack
// replaces the top in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             underflow
);

  localparam int unsigned PtrW = ras_ptr_width(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  // ptr_q is the next free slot; the top lives one below it (mod depth).
  logic [PtrW-1:0]  ptr_q, ptr_d, top_idx, wr_idx;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             underflow_q, underflow_d;
  logic             wr_en;

  assign top_idx   = ptr_q - PtrW'(1);
  assign top       = mem_q[top_idx];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == DepthCnt);
  assign underflow = underflow_q;

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
    underflow_d = 1'b0;
    if (pop && !empty) begin
      if (push) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CntW'(1);
      end
    end else begin
      underflow_d = pop;
      if (push) begin
        wr_en = 1'b1;
        ptr_d = ptr_q + PtrW'(1);
        if (!full) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
      if (wr_en) begin
        mem_q[wr_idx] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_control_unit.sv
// Program-counter unit: PC register with branch evaluation, exception
// redirect/EPC capture/return, and a circular return-address stack.
//   clk, reset            : clock, asynchronous active-high reset
//   pc_write, pc_write_cond, branch_ne, alu_zero, pc_in : normal/branch PC load
//   exception, eret       : trap redirect to EXC_VECTOR / return to epc
//   ras_push, ras_pop     : call/return via the RAS
//   pc_out, epc           : current PC, exception PC
//   ras_empty, ras_full, ras_underflow : RAS status
//   pc_updated, misaligned : registered one-cycle pulses
// Optional macro PC_ALIGN_CHECK_EN: misaligned targets trap to EXC_VECTOR
// with the target recorded in epc; otherwise misaligned is tied low.
module pc_control_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             branch_ne,
  input  logic             alu_zero,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             exception,
  input  logic             eret,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow,
  output logic             pc_updated,
  output logic             misaligned
);

  logic             take;
  pc_src_e          src;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
  logic             updated_q, updated_d;
  logic             ras_push_en, ras_pop_en;

  assign take = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));

  always_comb begin
    if (exception) begin
      src = PcSrcExc;
    end else if (eret) begin
      src = PcSrcEret;
    end else if (ras_pop && !ras_empty) begin
      src = PcSrcRas;
    end else if (ras_pop) begin
      src = PcSrcHold;  // underflow: PC held
    end else if (take) begin
      src = PcSrcTake;
    end else begin
      src = PcSrcHold;
    end
  end

  always_comb begin
    target = pc_in;
    if (src == PcSrcEret) begin
      target = epc_q;
    end else if (src == PcSrcRas) begin
      target = ras_top;
    end
  end

  // Exception suppresses both stack ops; eret outranks a pop, so the pop is
  // only performed when it is the selected row.
  assign ras_push_en = ras_push & ~exception;
  assign ras_pop_en  = ras_pop & ~exception & ~eret;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
`endif

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
`ifdef PC_ALIGN_CHECK_EN
    misaligned_d = 1'b0;
`endif
    if (src == PcSrcExc) begin
      epc_d = pc_q;
      pc_d  = EXC_VECTOR;
    end else if (src != PcSrcHold) begin
`ifdef PC_ALIGN_CHECK_EN
      if (target[1:0] != 2'b00) begin
        epc_d        = target;
        pc_d         = EXC_VECTOR;
        misaligned_d = 1'b1;
      end else begin
        pc_d = target;
      end
`else
      pc_d = target;
`endif
    end
  end

  assign updated_d = (src != PcSrcHold);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      updated_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      updated_q <= updated_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  assign pc_out     = pc_q;
  assign epc        = epc_q;
  assign pc_updated = updated_q;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push_en),
    .pop       (ras_pop_en),
    .push_data (pc_q),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_pc_control_unit.sv
// Self-checking bench for pc_control_unit: a directed vector table, a few
// hand-written sequences (async reset, alignment), and randomized stimulus
// against a queue-based reference model.
module tb_pc_control_unit;

  localparam int unsigned D   = 4;
  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_write, pc_write_cond, branch_ne, alu_zero;
  logic [31:0] pc_in;
  logic        exception, eret, ras_push, ras_pop;
  logic [31:0] pc_out, epc;
  logic        ras_empty, ras_full, ras_underflow, pc_updated, misaligned;

  always #5 clk = ~clk;

  pc_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .alu_zero      (alu_zero),
    .pc_in         (pc_in),
    .exception     (exception),
    .eret          (eret),
    .ras_push      (ras_push),
    .ras_pop       (ras_pop),
    .pc_out        (pc_out),
    .epc           (epc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_underflow (ras_underflow),
    .pc_updated    (pc_updated),
    .misaligned    (misaligned)
  );

  typedef struct {
    logic        pw, pwc, bne, zero;
    logic [31:0] pin;
    logic        exc, eret, push, pop;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] e_pc, e_epc;
    logic        e_upd, e_unf, e_empty, e_full;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_upd, m_unf, m_mis;
  logic [31:0] m_ras[$];

  function automatic stim_t st(input logic pw, pwc, bne, zero, input logic [31:0] pin,
                               input logic exc, er, push, pop);
    stim_t s;
    s.pw = pw; s.pwc = pwc; s.bne = bne; s.zero = zero; s.pin = pin;
    s.exc = exc; s.eret = er; s.push = push; s.pop = pop;
    return s;
  endfunction

  function automatic vec_t vv(input stim_t s, input logic [31:0] pc, ep,
                              input logic upd, unf, emp, full);
    vec_t v;
    v.s = s; v.e_pc = pc; v.e_epc = ep; v.e_upd = upd; v.e_unf = unf;
    v.e_empty = emp; v.e_full = full;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input stim_t s);
    pc_write = s.pw; pc_write_cond = s.pwc; branch_ne = s.bne; alu_zero = s.zero;
    pc_in = s.pin; exception = s.exc; eret = s.eret; ras_push = s.push; ras_pop = s.pop;
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    set_inputs(s);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_upd = 1'b0; m_unf = 1'b0; m_mis = 1'b0;
    m_ras.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_inputs(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Behavioural model of one clock edge, from the priority rules.
  task automatic model_step(input stim_t s);
    logic        take, load;
    logic [31:0] tgt;
    int          n;
    take = s.pw | (s.pwc & (s.zero != s.bne));
    load = 1'b0; tgt = 32'h0;
    m_upd = 1'b0; m_unf = 1'b0; m_mis = 1'b0;
    n = m_ras.size();
    if (s.exc) begin
      m_epc = m_pc;
      m_pc  = EXC;
      m_upd = 1'b1;
    end else begin
      if (s.eret) begin
        tgt = m_epc; load = 1'b1;
      end else if (s.pop && n > 0) begin
        tgt = m_ras[n-1]; load = 1'b1;
      end else if (s.pop) begin
        m_unf = 1'b1;
      end else if (take) begin
        tgt = s.pin; load = 1'b1;
      end
      if (s.pop && !s.eret && n > 0) begin
        if (s.push) m_ras[n-1] = m_pc;
        else void'(m_ras.pop_back());
      end else if (s.push) begin
        if (n == D) void'(m_ras.pop_front());
        m_ras.push_back(m_pc);
      end
      if (load) begin
        m_upd = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        if (tgt % 4 != 0) begin
          m_epc = tgt; m_pc = EXC; m_mis = 1'b1;
        end else begin
          m_pc = tgt;
        end
`else
        m_pc = tgt;
`endif
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc"}, pc_out, m_pc);
    check({tag, " epc"}, epc, m_epc);
    check({tag, " upd"}, {31'b0, pc_updated}, {31'b0, m_upd});
    check({tag, " unf"}, {31'b0, ras_underflow}, {31'b0, m_unf});
    check({tag, " mis"}, {31'b0, misaligned}, {31'b0, m_mis});
    check({tag, " empty"}, {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
    check({tag, " full"}, {31'b0, ras_full}, {31'b0, (m_ras.size() == D)});
  endtask

  vec_t vecs[$];

  initial begin
    set_inputs(st(0, 0, 0, 0, 0, 0, 0, 0, 0));

    //           pw pwc bne z  pc_in    exc er psh pop     pc     epc   upd unf emp full
    vecs.push_back(vv(st(0,1,0,1,32'h100,0,0,0,0), 32'h100, 32'h00, 1,0,1,0));
    vecs.push_back(vv(st(0,1,1,1,32'h200,0,0,0,0), 32'h100, 32'h00, 0,0,1,0));
    vecs.push_back(vv(st(0,1,1,0,32'h024,0,0,0,0), 32'h024, 32'h00, 1,0,1,0));
    vecs.push_back(vv(st(0,1,0,0,32'h300,0,0,0,0), 32'h024, 32'h00, 0,0,1,0));
    vecs.push_back(vv(st(1,0,0,0,32'h500,1,0,0,0), EXC,     32'h24, 1,0,1,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,1,0,0), 32'h024, 32'h24, 1,0,1,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,1,1,0,0), EXC,     32'h24, 1,0,1,0));
    vecs.push_back(vv(st(1,0,0,0,32'h010,0,0,0,0), 32'h010, 32'h24, 1,0,1,0));
    vecs.push_back(vv(st(1,0,0,0,32'h020,0,0,1,0), 32'h020, 32'h24, 1,0,0,0));
    vecs.push_back(vv(st(1,0,0,0,32'h030,0,0,1,0), 32'h030, 32'h24, 1,0,0,0));
    vecs.push_back(vv(st(1,0,0,0,32'h040,0,0,1,0), 32'h040, 32'h24, 1,0,0,0));
    vecs.push_back(vv(st(1,0,0,0,32'h050,0,0,1,0), 32'h050, 32'h24, 1,0,0,1));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,1,0), 32'h050, 32'h24, 0,0,0,1));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,0,1), 32'h050, 32'h24, 1,0,0,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,0,1), 32'h040, 32'h24, 1,0,0,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,0,1), 32'h030, 32'h24, 1,0,0,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,0,1), 32'h020, 32'h24, 1,0,1,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,0,1), 32'h020, 32'h24, 0,1,1,0));
    vecs.push_back(vv(st(1,0,0,0,32'h200,0,0,0,0), 32'h200, 32'h24, 1,0,1,0));
    vecs.push_back(vv(st(1,0,0,0,32'h300,0,0,1,0), 32'h300, 32'h24, 1,0,0,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,1,1), 32'h200, 32'h24, 1,0,0,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,0,1), 32'h300, 32'h24, 1,0,1,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,1,1), 32'h300, 32'h24, 0,1,0,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,0,1), 32'h300, 32'h24, 1,0,1,0));
    vecs.push_back(vv(st(1,0,0,0,32'h044,0,0,0,0), 32'h044, 32'h24, 1,0,1,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,1,0,1,0), EXC,     32'h44, 1,0,1,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,1,0,0), 32'h044, 32'h44, 1,0,1,0));
    vecs.push_back(vv(st(0,0,0,0,32'h000,0,0,0,1), 32'h044, 32'h44, 0,1,1,0));

    // Power-on reset state
    #1 reset = 1'b1;
    #1;
    check("por pc", pc_out, 32'h0);
    check("por epc", epc, 32'h0);
    check("por empty", {31'b0, ras_empty}, 32'h1);
    check("por full", {31'b0, ras_full}, 32'h0);
    check("por upd", {31'b0, pc_updated}, 32'h0);
    check("por unf", {31'b0, ras_underflow}, 32'h0);
    check("por mis", {31'b0, misaligned}, 32'h0);
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].s);
      check($sformatf("vec%0d pc", i), pc_out, vecs[i].e_pc);
      check($sformatf("vec%0d epc", i), epc, vecs[i].e_epc);
      check($sformatf("vec%0d upd", i), {31'b0, pc_updated}, {31'b0, vecs[i].e_upd});
      check($sformatf("vec%0d unf", i), {31'b0, ras_underflow}, {31'b0, vecs[i].e_unf});
      check($sformatf("vec%0d empty", i), {31'b0, ras_empty}, {31'b0, vecs[i].e_empty});
      check($sformatf("vec%0d full", i), {31'b0, ras_full}, {31'b0, vecs[i].e_full});
      check($sformatf("vec%0d mis", i), {31'b0, misaligned}, 32'h0);
    end

    // Asynchronous reset mid-run with pc_out=0x40, epc and RAS populated
    drive(st(1, 0, 0, 0, 32'h40, 0, 0, 0, 0));
    drive(st(0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    drive(st(0, 0, 0, 0, 32'h0, 0, 1, 0, 0));
    drive(st(0, 0, 0, 0, 32'h0, 0, 0, 1, 0));
    check("pre-rst pc", pc_out, 32'h40);
    check("pre-rst empty", {31'b0, ras_empty}, 32'h0);
    @(negedge clk);
    set_inputs(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b1;
    #1;
    check("arst pc", pc_out, 32'h0);
    check("arst epc", epc, 32'h0);
    check("arst empty", {31'b0, ras_empty}, 32'h1);
    check("arst upd", {31'b0, pc_updated}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Misaligned target
    drive(st(1, 0, 0, 0, 32'h102, 0, 0, 0, 0));
`ifdef PC_ALIGN_CHECK_EN
    check("align pc", pc_out, EXC);
    check("align epc", epc, 32'h102);
    check("align mis", {31'b0, misaligned}, 32'h1);
`else
    check("align pc", pc_out, 32'h102);
    check("align epc", epc, 32'h0);
    check("align mis", {31'b0, misaligned}, 32'h0);
`endif
    drive(st(0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    check("align mis clr", {31'b0, misaligned}, 32'h0);

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      stim_t s;
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(7) != 0) r[1:0] = 2'b00;
      s = st($urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
             $urandom_range(1) == 1, r, $urandom_range(11) == 0, $urandom_range(9) == 0,
             $urandom_range(2) == 0, $urandom_range(3) == 0);
      if (s.eret) s.pop = 1'b0;
      drive(s);
      model_step(s);
      check_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
